// File: rtl/processor_if.sv
// Bus bundle between the processor and its instruction source / memory.
// master = processor side, slave = memory/instruction-source side.
interface processor_if;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] out;
  logic        rw;
  logic        sys_dne;

  modport master (
    input  instruction,
    output addr,
    output out,
    output rw,
    output sys_dne
  );

  modport slave (
    output instruction,
    input  addr,
    input  out,
    input  rw,
    input  sys_dne
  );
endinterface

// File: rtl/processor.sv
// Multi-cycle 32-bit processor: FETCH/EXEC/EXTRA/DONE controller,
// 32 x 32 register file, registered memory-write port.
module processor (
  input  logic        clk,
  input  logic        reset,
  processor_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    EXTRA = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_HALT  = 6'h01;
  localparam logic [5:0] OP_MOVE  = 6'h02;
  localparam logic [5:0] OP_COPY  = 6'h03;
  localparam logic [5:0] OP_ADD   = 6'h04;
  localparam logic [5:0] OP_SUB   = 6'h05;
  localparam logic [5:0] OP_AND   = 6'h06;
  localparam logic [5:0] OP_OR    = 6'h07;
  localparam logic [5:0] OP_STORE = 6'h09;
  localparam logic [5:0] OP_LOADI = 6'h0A;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] out_q, out_d;
  logic        rw_q, rw_d;
  logic        dne_q, dne_d;

  logic [31:0] rf_q [32];

  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [5:0]  op;
  logic [4:0]  rs, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rd_val;

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rd     = ir_q[20:16];
  assign imm    = ir_q[15:0];
  assign rs_val = rf_q[rs];
  assign rd_val = rf_q[rd];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    out_d   = out_q;
    rw_d    = 1'b0;
    dne_d   = dne_q;
    we      = 1'b0;
    waddr   = rd;
    wdata   = rs_val;

    unique case (state_q)
      FETCH: begin
        ir_d    = bus.instruction;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          OP_LOADI: begin
            we    = 1'b1;
            waddr = rs;
            wdata = sext16(imm);
          end
          OP_MOVE: begin
            we      = 1'b1;
            state_d = EXTRA;
          end
          OP_COPY: we = 1'b1;
          OP_ADD: begin
            we    = 1'b1;
            wdata = rd_val + rs_val;
          end
          OP_SUB: begin
            we    = 1'b1;
            wdata = rd_val - rs_val;
          end
          OP_AND: begin
            we    = 1'b1;
            wdata = rd_val & rs_val;
          end
          OP_OR: begin
            we    = 1'b1;
            wdata = rd_val | rs_val;
          end
          OP_STORE: begin
            // Address/data latch here so they are stable for the whole strobe cycle.
            addr_d  = rs_val + sext16(imm);
            out_d   = rd_val;
            rw_d    = 1'b1;
            state_d = EXTRA;
          end
          OP_HALT: begin
            dne_d   = 1'b1;
            state_d = DONE;
          end
          default: ;
        endcase
      end
      EXTRA: begin
        state_d = FETCH;
        if (op == OP_MOVE) begin
          we    = 1'b1;
          waddr = rs;
          wdata = '0;
        end
      end
      DONE: begin
        state_d = DONE;
        dne_d   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      ir_q    <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      rw_q    <= 1'b0;
      dne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      rw_q    <= rw_d;
      dne_q   <= dne_d;
    end
  end

  // Register file is never cleared, but reset still blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.out     = out_q;
  assign bus.rw      = rw_q;
  assign bus.sys_dne = dne_q;

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: hand-computed vectors, immediate assertions.
module tb_processor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total_cnt = 0;
  int   pass_cnt = 0;

  processor_if bus_if ();

  processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs, rd, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Apply an instruction and advance n rising edges; sample 1 time unit after the edge.
  task automatic run(input logic [31:0] instr, input int n);
    bus_if.instruction = instr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] st();
    return {30'b0, dut.state_q};
  endfunction

  initial begin
    bus_if.instruction = '0;
    reset = 1'b0;
    run(32'h0, 2);
    chk("rst_state", st(), 32'd0);
    chk("rst_ir", dut.ir_q, 32'h0);
    chk("rst_addr", bus_if.addr, 32'h0);
    chk("rst_out", bus_if.out, 32'h0);
    chk("rst_rw", {31'b0, bus_if.rw}, 32'd0);
    chk("rst_dne", {31'b0, bus_if.sys_dne}, 32'd0);
    reset = 1'b1;

    run(32'h28E0A51B, 2);
    chk("loadi_r7", dut.rf_q[7], 32'hFFFFA51B);
    chk("loadi_state", st(), 32'd0);

    run(32'h08E80000, 2);
    chk("move_exec_state", st(), 32'd2);
    chk("move_exec_r8", dut.rf_q[8], 32'hFFFFA51B);
    chk("move_exec_r7", dut.rf_q[7], 32'hFFFFA51B);
    run(32'h08E80000, 1);
    chk("move_r7", dut.rf_q[7], 32'h0);
    chk("move_r8", dut.rf_q[8], 32'hFFFFA51B);
    chk("move_state", st(), 32'd0);

    run(32'h0D070000, 2);
    chk("copy_r7", dut.rf_q[7], 32'hFFFFA51B);
    chk("copy_r8", dut.rf_q[8], 32'hFFFFA51B);

    run(enc(6'h0A, 5'd1, 5'd0, 16'h0005), 2);
    run(enc(6'h0A, 5'd2, 5'd0, 16'hFFFF), 2);
    chk("loadi_r2_neg", dut.rf_q[2], 32'hFFFFFFFF);
    run(enc(6'h04, 5'd2, 5'd1, 16'h0), 2);
    chk("add_wrap", dut.rf_q[1], 32'h00000004);
    chk("add_src", dut.rf_q[2], 32'hFFFFFFFF);
    run(enc(6'h05, 5'd2, 5'd2, 16'h0), 2);
    chk("sub_equal", dut.rf_q[2], 32'h0);

    run(enc(6'h0A, 5'd3, 5'd0, 16'h0F0F), 2);
    run(enc(6'h0A, 5'd4, 5'd0, 16'h00FF), 2);
    run(enc(6'h0A, 5'd5, 5'd0, 16'h7000), 2);
    run(enc(6'h06, 5'd4, 5'd3, 16'h0), 2);
    chk("and", dut.rf_q[3], 32'h0000000F);
    run(enc(6'h07, 5'd5, 5'd4, 16'h0), 2);
    chk("or", dut.rf_q[4], 32'h000070FF);
    run(enc(6'h05, 5'd3, 5'd1, 16'h0), 2);
    chk("sub_borrow", dut.rf_q[1], 32'hFFFFFFF5);

    run(enc(6'h0A, 5'd9, 5'd0, 16'h1234), 2);
    run(enc(6'h02, 5'd9, 5'd9, 16'h0), 2);
    chk("move_same_exec", dut.rf_q[9], 32'h00001234);
    run(enc(6'h02, 5'd9, 5'd9, 16'h0), 1);
    chk("move_same_final", dut.rf_q[9], 32'h0);
    run(enc(6'h0A, 5'd10, 5'd0, 16'h0077), 2);
    run(enc(6'h03, 5'd10, 5'd10, 16'h0), 2);
    chk("copy_same", dut.rf_q[10], 32'h00000077);

    run(enc(6'h00, 5'd1, 5'd3, 16'h1111), 2);
    chk("nop_r1", dut.rf_q[1], 32'hFFFFFFF5);
    chk("nop_r3", dut.rf_q[3], 32'h0000000F);
    run(enc(6'h3F, 5'd3, 5'd1, 16'hFFFF), 2);
    chk("undef_r1", dut.rf_q[1], 32'hFFFFFFF5);
    chk("undef_state", st(), 32'd0);
    chk("undef_rw", {31'b0, bus_if.rw}, 32'd0);

    run(enc(6'h0A, 5'd2, 5'd0, 16'h0100), 2);
    run(enc(6'h0A, 5'd1, 5'd0, 16'h00AB), 2);
    run(enc(6'h09, 5'd2, 5'd1, 16'h0004), 1);
    chk("st_fetch_rw", {31'b0, bus_if.rw}, 32'd0);
    run(enc(6'h09, 5'd2, 5'd1, 16'h0004), 1);
    chk("st_extra_state", st(), 32'd2);
    chk("st_rw", {31'b0, bus_if.rw}, 32'd1);
    chk("st_addr", bus_if.addr, 32'h00000104);
    chk("st_out", bus_if.out, 32'h000000AB);
    run(32'h0, 1);
    chk("st_after_rw", {31'b0, bus_if.rw}, 32'd0);
    chk("st_after_state", st(), 32'd0);
    chk("st_hold_addr", bus_if.addr, 32'h00000104);
    chk("st_hold_out", bus_if.out, 32'h000000AB);

    run(enc(6'h09, 5'd2, 5'd1, 16'hFFFC), 2);
    chk("st_neg_addr", bus_if.addr, 32'h000000FC);
    chk("st_neg_rw", {31'b0, bus_if.rw}, 32'd1);
    reset = 1'b0;
    run(32'h0, 1);
    chk("st_rst_rw", {31'b0, bus_if.rw}, 32'd0);
    chk("st_rst_addr", bus_if.addr, 32'h0);
    chk("st_rst_out", bus_if.out, 32'h0);
    reset = 1'b1;

    run(enc(6'h0A, 5'd3, 5'd0, 16'h0055), 2);
    run(enc(6'h02, 5'd3, 5'd4, 16'h0), 2);
    chk("mvrst_extra", st(), 32'd2);
    reset = 1'b0;
    run(32'h0, 1);
    chk("mvrst_rs", dut.rf_q[3], 32'h00000055);
    chk("mvrst_rd", dut.rf_q[4], 32'h00000055);
    chk("mvrst_state", st(), 32'd0);
    reset = 1'b1;

    run(enc(6'h01, 5'd0, 5'd0, 16'h0), 2);
    chk("halt_dne", {31'b0, bus_if.sys_dne}, 32'd1);
    chk("halt_state", st(), 32'd3);
    for (int i = 0; i < 10; i++) begin
      run($urandom, 1);
      chk("halt_hold_dne", {31'b0, bus_if.sys_dne}, 32'd1);
      chk("halt_hold_rw", {31'b0, bus_if.rw}, 32'd0);
    end
    chk("halt_hold_state", st(), 32'd3);
    reset = 1'b0;
    run(32'h0, 1);
    chk("halt_rst_dne", {31'b0, bus_if.sys_dne}, 32'd0);
    chk("halt_rst_state", st(), 32'd0);
    reset = 1'b1;

    run(enc(6'h0A, 5'd11, 5'd0, 16'h0003), 2);
    chk("post_rst_loadi", dut.rf_q[11], 32'h00000003);
    chk("post_rst_state", st(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 instruction  input  32  instruction word, sampled only in FETCH.
REQ-005 addr  output  32  memory address, valid while rw=1.
REQ-006 out  output  32  store data, valid while rw=1.
REQ-007 rw  output  1  1 = memory write strobe, 0 = idle or read.
REQ-008 sys_dne  output  1  1 = processor halted.

Function
REQ-009 Register file SHALL be 32 x 32-bit, R0..R31, all general purpose, with no hardwired zero.
REQ-010 Instruction format: op=[31:26], rs=[25:21], rd=[20:16], imm=[15:0]; sext(imm) is the 16-to-32 sign extension.
REQ-011 Controller states: FETCH, EXEC, EXTRA, DONE; 2-bit encoding FETCH=0, EXEC=1, EXTRA=2, DONE=3.
REQ-012 FETCH: latch instruction into the internal IR and go to EXEC; no register write occurs.
REQ-013 0x0A LOADI: in EXEC, R[rs] <= sext(imm), then go to FETCH (2 cycles total).
REQ-014 0x02 MOVE: in EXEC, R[rd] <= R[rs]; in EXTRA, R[rs] <= 0, then go to FETCH (3 cycles total).
REQ-015 0x03 COPY: in EXEC, R[rd] <= R[rs], then go to FETCH; the source is unchanged (2 cycles total).
REQ-016 0x04 ADD, 0x05 SUB, 0x06 AND, 0x07 OR: in EXEC, R[rd] <= R[rd] op R[rs], then go to FETCH.
  - Arithmetic is mod 2^32.
  - Carry and borrow are discarded; there are no flags.
REQ-017 0x09 STORE: EXEC latches addr <= R[rs] + sext(imm) and out <= R[rd]; EXTRA drives rw=1 for exactly one cycle, then goes to FETCH.
REQ-018 0x01 HALT: EXEC goes to DONE; in DONE, sys_dne=1, rw=0, and the controller stays in DONE until reset.
REQ-019 0x00 and all undefined opcodes: NOP, EXEC goes to FETCH with no state change.
REQ-020 When rs == rd:
  - MOVE writes R[rd] in EXEC, then clears it in EXTRA (final value 0).
  - COPY is a no-op.
REQ-021 rw SHALL be 1 only in the EXTRA state of STORE; addr and out hold their last latched values at all other times.
REQ-022 All register and state updates occur on the rising clk edge; outputs are registered.

Reset
REQ-023 On a rising clk edge with reset=0:
  - state <= FETCH, IR <= 0.
  - addr <= 0, out <= 0, rw <= 0, sys_dne <= 0.
  - Reset overrides any in-progress instruction, including a STORE mid-EXTRA and DONE.
REQ-024 The register file SHALL NOT be reset; unwritten registers read X in simulation.
REQ-025 After reset releases, the first rising edge with reset=1 performs FETCH.

Verification
REQ-026 Reset, then LOADI 0x28E0A51B over 2 edges -> R7=0xFFFFA51B, R8=X, state=FETCH.
REQ-027 Then MOVE 0x08E80000 over 3 edges -> R7=0x00000000, R8=0xFFFFA51B.
REQ-028 Then COPY 0x0D070000 over 2 edges -> R7=0xFFFFA51B, R8=0xFFFFA51B.
REQ-029 LOADI R1=5, LOADI R2=0xFFFF, then ADD rd=1 rs=2 -> R1=0x00000004 (wrap); SUB of equal values -> 0.
REQ-030 STORE rd=1 rs=2 imm=0x0004 with R2=0x100, R1=0xAB:
  - rw=1 for exactly one cycle.
  - addr=0x104, out=0xAB during that cycle.
REQ-031 HALT -> sys_dne=1 and stays 1 across 10 edges with instruction changing.
  - Reset low for one edge -> sys_dne=0, state=FETCH.
  - Asserting reset during MOVE EXTRA leaves the rs register unchanged.
